// File: rtl/winograd_conv7x3_if.sv
`default_nettype none
// ============================================================================
// Module      : winograd_conv7x3_if
// Description : Tile/result bus for the winograd_conv7x3 engine. The master
//               (tile buffer side) drives the 9-sample tile D; the slave
//               (convolution engine) drives the 7-element result Z.
//               d0 sits in the MSB field of D, y0 in the MSB field of Z.
// Revision    : 1.0 - initial release
// ============================================================================
interface winograd_conv7x3_if #(
    parameter int DW = 10
);
    logic [9*DW-1:0] D;
    logic [7*DW-1:0] Z;

    modport master (output D, input Z);
    modport slave  (input D, output Z);
endinterface
`default_nettype wire

// File: rtl/winograd_conv7x3.sv
`default_nettype none
// ============================================================================
// Module      : winograd_conv7x3
// Description : Pipelined 1-D "valid" convolution of a 9-sample signed tile
//               with a compile-time 3-tap kernel (F(7,3) tile geometry):
//                   y_i = G0*d_i + G1*d_(i+1) + G2*d_(i+2), i = 0..6
//               Three register stages: tile capture, tap products, result.
//               One tile per clock, no handshake, synchronous active-high rst.
//               Build option: define WC_SAT_EN to saturate each y_i to the
//               DW-bit signed range instead of wrapping mod 2^DW.
// Revision    : 1.0 - initial release
// ============================================================================
module winograd_conv7x3 #(
    parameter int DW = 10,
    parameter int G0 = 1,
    parameter int G1 = 2,
    parameter int G2 = 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    winograd_conv7x3_if.slave       bus
);

    // Internal precision: |tap| <= 15 needs 4 magnitude bits per product and
    // the three-term sum needs 2 more, so DW+6 never overflows.
    localparam int PW = DW + 6;

    localparam logic signed [PW-1:0] c_G0 = PW'(G0);
    localparam logic signed [PW-1:0] c_G1 = PW'(G1);
    localparam logic signed [PW-1:0] c_G2 = PW'(G2);

`ifdef WC_SAT_EN
    localparam logic signed [PW-1:0] c_MAX = PW'((2 ** (DW - 1)) - 1);
    localparam logic signed [PW-1:0] c_MIN = PW'(-(2 ** (DW - 1)));
`endif

    logic signed [DW-1:0] r_d  [9];
    logic signed [PW-1:0] r_p0 [7];
    logic signed [PW-1:0] r_p1 [7];
    logic signed [PW-1:0] r_p2 [7];
    logic        [7*DW-1:0] r_z;
    logic        [DW-1:0]   w_y  [7];

    // Stage 1: capture the incoming tile, unpacking d0 from the MSB field.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 9; k++) begin
            if (rst) begin
                r_d[k] <= '0;
            end else begin
                r_d[k] <= bus.D[(8-k)*DW +: DW];
            end
        end
    end

    // Stage 2: register the three sign-extended tap products of each output.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 7; i++) begin
            if (rst) begin
                r_p0[i] <= '0;
                r_p1[i] <= '0;
                r_p2[i] <= '0;
            end else begin
                r_p0[i] <= PW'(r_d[i])   * c_G0;
                r_p1[i] <= PW'(r_d[i+1]) * c_G1;
                r_p2[i] <= PW'(r_d[i+2]) * c_G2;
            end
        end
    end

    // Full-precision sum of the products, reduced to DW bits.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_out
`ifdef WC_SAT_EN
            logic signed [PW-1:0] w_sum;
            assign w_sum   = r_p0[gi] + r_p1[gi] + r_p2[gi];
            assign w_y[gi] = (w_sum > c_MAX) ? DW'(c_MAX) :
                             (w_sum < c_MIN) ? DW'(c_MIN) :
                                               w_sum[DW-1:0];
`else
            assign w_y[gi] = DW'(r_p0[gi] + r_p1[gi] + r_p2[gi]);
`endif
        end
    endgenerate

    // Stage 3: register the results, y0 into the MSB field of Z.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z <= '0;
        end else begin
            for (int i = 0; i < 7; i++) begin
                r_z[(6-i)*DW +: DW] <= w_y[i];
            end
        end
    end

    assign bus.Z = r_z;

endmodule
`default_nettype wire

// File: tb/tb_winograd_conv7x3.sv
`default_nettype none
// ============================================================================
// Module      : tb_winograd_conv7x3
// Description : Directed self-checking bench for winograd_conv7x3 with the
//               default kernel (1,2,1), DW = 10. Expected results are hand
//               computed; overflow expectations follow WC_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_winograd_conv7x3;

    localparam int DW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    winograd_conv7x3_if #(.DW(DW)) bus ();

    winograd_conv7x3 #(.DW(DW), .G0(1), .G1(2), .G2(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int t1_d [9] = '{2, -10, 3, 4, -13, -18, -16, -28, -11};
    int t1_y [7] = '{-15, 0, -2, -40, -65, -78, -83};
    int t2_d [9] = '{-19, -6, 3, -9, -12, 11, -4, 0, -7};
    int t2_y [7] = '{-28, -9, -27, -22, 6, 3, -11};

    function automatic logic [9*DW-1:0] pack9(input int v [9]);
        logic [9*DW-1:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[(8-k)*DW +: DW] = DW'(v[k]);
        return r;
    endfunction

    function automatic logic [7*DW-1:0] pack7(input int v [7]);
        logic [7*DW-1:0] r;
        r = '0;
        for (int k = 0; k < 7; k++) r[(6-k)*DW +: DW] = DW'(v[k]);
        return r;
    endfunction

    function automatic logic [9*DW-1:0] fill9(input int v);
        logic [9*DW-1:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[k*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [7*DW-1:0] fill7(input int v);
        logic [7*DW-1:0] r;
        r = '0;
        for (int k = 0; k < 7; k++) r[k*DW +: DW] = DW'(v);
        return r;
    endfunction

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            bus.D = {$urandom, $urandom, $urandom};
            tick();
            n_checks++;
            if (bus.Z !== '0) begin
                n_fail++;
                $display("FAIL reset_cycle%0d: Z=%h expected 0", c, bus.Z);
            end
        end
    endtask

    task automatic test_tile1();
        logic [7*DW-1:0] exp_z;
        exp_z = pack7(t1_y);
        rst   = 1'b0;
        bus.D = pack9(t1_d);
        tick();
        n_checks++;
        if (bus.Z !== '0) begin
            n_fail++;
            $display("FAIL tile1_fill1: Z=%h expected 0", bus.Z);
        end
        bus.D = '0;
        tick();
        n_checks++;
        if (bus.Z !== '0) begin
            n_fail++;
            $display("FAIL tile1_fill2: Z=%h expected 0", bus.Z);
        end
        tick();
        n_checks++;
        if (bus.Z !== exp_z) begin
            n_fail++;
            $display("FAIL tile1_result: Z=%h expected %h", bus.Z, exp_z);
        end
    endtask

    task automatic test_tile2();
        logic [7*DW-1:0] exp_z;
        exp_z = pack7(t2_y);
        bus.D = pack9(t2_d);
        tick();
        bus.D = '0;
        tick();
        tick();
        n_checks++;
        if (bus.Z !== exp_z) begin
            n_fail++;
            $display("FAIL tile2_result: Z=%h expected %h", bus.Z, exp_z);
        end
    endtask

    task automatic test_back_to_back();
        logic [7*DW-1:0] e1, e2;
        e1 = pack7(t1_y);
        e2 = pack7(t2_y);
        bus.D = pack9(t1_d);
        tick();
        bus.D = pack9(t2_d);
        tick();
        bus.D = '0;
        tick();
        n_checks++;
        if (bus.Z !== e1) begin
            n_fail++;
            $display("FAIL b2b_first: Z=%h expected %h", bus.Z, e1);
        end
        tick();
        n_checks++;
        if (bus.Z !== e2) begin
            n_fail++;
            $display("FAIL b2b_second: Z=%h expected %h", bus.Z, e2);
        end
        tick();
        n_checks++;
        if (bus.Z !== '0) begin
            n_fail++;
            $display("FAIL b2b_drain: Z=%h expected 0", bus.Z);
        end
    endtask

    task automatic test_overflow();
        logic [7*DW-1:0] e_pos, e_neg;
`ifdef WC_SAT_EN
        e_pos = fill7(511);
        e_neg = fill7(-512);
`else
        e_pos = fill7(-4);
        e_neg = fill7(0);
`endif
        bus.D = fill9(511);
        tick();
        bus.D = fill9(-512);
        tick();
        bus.D = '0;
        tick();
        n_checks++;
        if (bus.Z !== e_pos) begin
            n_fail++;
            $display("FAIL overflow_pos: Z=%h expected %h", bus.Z, e_pos);
        end
        tick();
        n_checks++;
        if (bus.Z !== e_neg) begin
            n_fail++;
            $display("FAIL overflow_neg: Z=%h expected %h", bus.Z, e_neg);
        end
    endtask

    task automatic test_midstream_reset();
        logic [7*DW-1:0] e2;
        e2 = pack7(t2_y);
        bus.D = pack9(t1_d);
        tick();
        rst   = 1'b1;
        bus.D = pack9(t1_d);
        tick();
        n_checks++;
        if (bus.Z !== '0) begin
            n_fail++;
            $display("FAIL midrst_in_reset: Z=%h expected 0", bus.Z);
        end
        rst   = 1'b0;
        bus.D = pack9(t2_d);
        tick();
        bus.D = '0;
        n_checks++;
        if (bus.Z !== '0) begin
            n_fail++;
            $display("FAIL midrst_after1: Z=%h expected 0", bus.Z);
        end
        tick();
        n_checks++;
        if (bus.Z !== '0) begin
            n_fail++;
            $display("FAIL midrst_after2: Z=%h expected 0", bus.Z);
        end
        tick();
        n_checks++;
        if (bus.Z !== e2) begin
            n_fail++;
            $display("FAIL midrst_next_tile: Z=%h expected %h", bus.Z, e2);
        end
    endtask

    task automatic test_hold();
        logic [7*DW-1:0] e1;
        e1 = pack7(t1_y);
        bus.D = pack9(t1_d);
        tick();
        tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (bus.Z !== e1) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: Z=%h expected %h", c, bus.Z, e1);
            end
        end
        bus.D = '0;
    endtask

    initial begin
        bus.D = '0;
        test_reset();
        test_tile1();
        test_tile2();
        test_back_to_back();
        test_overflow();
        test_midstream_reset();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
